// File: rtl/mul8u_sched_pkg.sv
// Shared types for the multiplier-sharing scheduler.
// Operand pair and product bundles used between pipeline stages.
package mul8u_sched_pkg;

   localparam int MUL_W  = 8;
   localparam int PROD_W = 16;

   typedef struct packed {
      logic [MUL_W-1:0] a;
      logic [MUL_W-1:0] b;
   } mul_op_t;

   typedef struct packed {
      logic [PROD_W-1:0] data;
   } mul_rsp_t;

endpackage

// File: rtl/mul8u_share_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first active request at or above
// ptr, wrapping modulo N. The pointer itself lives in the parent.
module rr_arbiter #(
   parameter int N   = 4,
   parameter int IDW = $clog2(N)
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] ptr,
   output logic [N-1:0]   gnt,
   output logic [IDW-1:0] gnt_id
);

   logic           found;
   int             idx;
   logic [IDW-1:0] idv;

   always_comb begin
      gnt    = '0;
      gnt_id = '0;
      found  = 1'b0;
      idx    = 0;
      idv    = '0;
      for (int k = 0; k < N; k++) begin
         idx = int'(ptr) + k;
         if (idx >= N) idx = idx - N;
         idv = IDW'(idx);
         if (!found && req[idv]) begin
            found    = 1'b1;
            gnt[idv] = 1'b1;
            gnt_id   = idv;
         end
      end
   end

endmodule

// File: rtl/mul8u_share_sched.sv
// Shares one external 8x8 multiplier among N requesters: round-robin
// issue stage drives the multiplier, result stage holds the product.
module mul8u_share_sched
   import mul8u_sched_pkg::*;
#(
   parameter int N   = 4,
   parameter int IDW = $clog2(N)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     req_valid,
   output logic [N-1:0]     req_ready,
   input  logic [N*8-1:0]   req_a,
   input  logic [N*8-1:0]   req_b,
   output logic [7:0]       mul_a,
   output logic [7:0]       mul_b,
   input  logic [15:0]      mul_o,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [IDW-1:0]   rsp_id,
   output logic [15:0]      rsp_data,
   output logic [15:0]      op_count
);

   logic           s1_valid;
   logic [IDW-1:0] s1_id;
   logic [IDW-1:0] rr_ptr;
   logic [IDW-1:0] ptr_next;
   logic [N-1:0]   gnt;
   logic [IDW-1:0] gnt_id;
   logic           s2_load;
   logic           s1_load_en;
   logic           accept;
   mul_op_t        sel;
   mul_rsp_t       rsp_q;

   rr_arbiter #(.N(N), .IDW(IDW)) u_arb (
      .req    (req_valid),
      .ptr    (rr_ptr),
      .gnt    (gnt),
      .gnt_id (gnt_id)
   );

   assign s2_load    = s1_valid & (~rsp_valid | rsp_ready);
   assign s1_load_en = ~s1_valid | s2_load;
   assign req_ready  = (s1_load_en && !rst) ? gnt : '0;
   assign accept     = |(req_valid & req_ready);

   assign sel.a    = req_a[int'(gnt_id)*MUL_W +: MUL_W];
   assign sel.b    = req_b[int'(gnt_id)*MUL_W +: MUL_W];
   assign ptr_next = (int'(gnt_id) == N-1) ? '0 : gnt_id + 1'b1;
   assign rsp_data = rsp_q.data;

   // Operand registers only move on accept, keeping mul_o stable in a stall
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_id    <= '0;
         mul_a    <= '0;
         mul_b    <= '0;
         rr_ptr   <= '0;
      end else begin
         if (accept) begin
            s1_valid <= 1'b1;
            s1_id    <= gnt_id;
            mul_a    <= sel.a;
            mul_b    <= sel.b;
            rr_ptr   <= ptr_next;
         end else if (s2_load) begin
            s1_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_q     <= '0;
         op_count  <= '0;
      end else begin
         if (s2_load) begin
            rsp_valid  <= 1'b1;
            rsp_id     <= s1_id;
            rsp_q.data <= mul_o;
         end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
         end
         if (rsp_valid && rsp_ready) op_count <= op_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_mul8u_share_sched.sv
// Bench for mul8u_share_sched: queue-based transaction model for N=4,
// plus a small N=3 instance for pointer wrap.
module tb_mul8u_share_sched;

   localparam int NR = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  req_valid;
   logic [3:0]  req_ready;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic [7:0]  mul_a;
   logic [7:0]  mul_b;
   logic [15:0] mul_o;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [1:0]  rsp_id;
   logic [15:0] rsp_data;
   logic [15:0] op_count;

   logic [2:0]  t_valid;
   logic [2:0]  t_ready;
   logic [23:0] t_a;
   logic [23:0] t_b;
   logic [7:0]  t_ma;
   logic [7:0]  t_mb;
   logic [15:0] t_mo;
   logic        t_rv;
   logic        t_rr;
   logic [1:0]  t_id;
   logic [15:0] t_data;
   logic [15:0] t_cnt;

   always #5 clk = ~clk;

   assign mul_o = {8'd0, mul_a} * {8'd0, mul_b};
   assign t_mo  = {8'd0, t_ma} * {8'd0, t_mb};

   mul8u_share_sched #(.N(4)) dut4 (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .mul_a     (mul_a),
      .mul_b     (mul_b),
      .mul_o     (mul_o),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data),
      .op_count  (op_count)
   );

   mul8u_share_sched #(.N(3)) dut3 (
      .clk       (clk),
      .rst       (rst),
      .req_valid (t_valid),
      .req_ready (t_ready),
      .req_a     (t_a),
      .req_b     (t_b),
      .mul_a     (t_ma),
      .mul_b     (t_mb),
      .mul_o     (t_mo),
      .rsp_valid (t_rv),
      .rsp_ready (t_rr),
      .rsp_id    (t_id),
      .rsp_data  (t_data),
      .op_count  (t_cnt)
   );

   typedef struct {
      int         id;
      logic [7:0] a;
      logic [7:0] b;
      bit         out;
   } op_t;

   op_t         q[$];
   int          ptr;
   int          cnt;
   logic [7:0]  last_a;
   logic [7:0]  last_b;
   bit          pv[NR];
   logic [7:0]  pa[NR];
   logic [7:0]  pb[NR];
   int          acc_log[$];
   int          rsp_log[$];
   int          dat_log[$];
   int          n_chk;
   int          n_pass;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic post(input int i, input logic [7:0] a,
                       input logic [7:0] b);
      if (!pv[i]) begin
         pv[i] = 1'b1;
         pa[i] = a;
         pb[i] = b;
      end
   endtask

   task automatic model_reset();
      q.delete();
      acc_log.delete();
      rsp_log.delete();
      dat_log.delete();
      ptr    = 0;
      cnt    = 0;
      last_a = 8'd0;
      last_b = 8'd0;
      for (int i = 0; i < NR; i++) pv[i] = 1'b0;
      req_valid = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // One clock of stimulus; the model advances to the state after the
   // following rising edge.
   task automatic step(input bit rr);
      bit         ev;
      bit         busy;
      int         g;
      int         idx;
      int         prod;
      logic [3:0] ev_rdy;
      op_t        h;
      @(negedge clk);
      ev = (q.size() > 0) && q[0].out;
      chk("rsp_valid", rsp_valid, ev);
      if (ev) begin
         prod = int'(q[0].a) * int'(q[0].b);
         chk("rsp_id", rsp_id, q[0].id);
         chk("rsp_data", rsp_data, prod);
      end
      chk("op_count", op_count, cnt % 65536);
      chk("mul_a", mul_a, last_a);
      chk("mul_b", mul_b, last_b);
      for (int i = 0; i < NR; i++) begin
         req_valid[i]       = pv[i];
         req_a[i*8 +: 8]    = pa[i];
         req_b[i*8 +: 8]    = pb[i];
      end
      rsp_ready = rr;
      #1;
      if (rsp_valid && rsp_ready) begin
         rsp_log.push_back(int'(rsp_id));
         dat_log.push_back(int'(rsp_data));
      end
      for (int i = 0; i < NR; i++)
         if (req_valid[i] && req_ready[i]) acc_log.push_back(i);
      if (ev && rr) begin
         void'(q.pop_front());
         cnt++;
      end
      if (q.size() > 0 && !q[0].out) begin
         h     = q[0];
         h.out = 1'b1;
         q[0]  = h;
      end
      busy = 1'b0;
      foreach (q[k]) if (!q[k].out) busy = 1'b1;
      g = -1;
      for (int k = 0; k < NR; k++) begin
         idx = (ptr + k) % NR;
         if (g < 0 && pv[idx]) g = idx;
      end
      ev_rdy = '0;
      if (!busy && g >= 0) ev_rdy[g] = 1'b1;
      chk("req_ready", req_ready, ev_rdy);
      if (ev_rdy != '0) begin
         h.id  = g;
         h.a   = pa[g];
         h.b   = pb[g];
         h.out = 1'b0;
         q.push_back(h);
         last_a = pa[g];
         last_b = pb[g];
         ptr    = (g + 1) % NR;
         pv[g]  = 1'b0;
      end
   endtask

   function automatic int at(input int qv[$], input int k);
      return (k < qv.size()) ? qv[k] : -1;
   endfunction

   initial begin
      int exp_f[6];
      int exp3[7];
      int iter;
      n_chk     = 0;
      n_pass    = 0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b0;
      t_valid   = 3'b111;
      t_a       = {8'd3, 8'd2, 8'd1};
      t_b       = {8'd7, 8'd6, 8'd5};
      t_rr      = 1'b1;
      model_reset();
      req_valid = 4'hf;

      // Reset values, with requests pending
      #12;
      chk("rst_req_ready", req_ready, 0);
      chk("rst_req_ready3", t_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_op_count", op_count, 0);
      chk("rst_mul_a", mul_a, 0);
      chk("rst_rsp_data", rsp_data, 0);
      req_valid = '0;
      @(negedge clk);
      rst = 1'b0;

      // N=3: pointer wraps 2 -> 0
      exp3 = '{0, 1, 2, 0, 1, 2, 0};
      for (int k = 0; k < 7; k++) begin
         #1;
         chk("n3_grant", t_ready, 1 << exp3[k]);
         @(negedge clk);
      end

      // Single op: requester 2, 200 x 150
      do_reset();
      post(2, 8'd200, 8'd150);
      step(1'b1);
      step(1'b1);
      step(1'b1);
      chk("single_valid", rsp_valid, 1);
      chk("single_id", rsp_id, 2);
      chk("single_data", rsp_data, 30000);
      step(1'b1);
      chk("single_count", op_count, 1);

      // Fairness with all four requesting
      do_reset();
      exp_f = '{0, 1, 2, 3, 0, 1};
      for (int c = 0; c < 8; c++) begin
         for (int i = 0; i < NR; i++)
            post(i, 8'(i * 16 + c), 8'(c + 3));
         step(1'b1);
      end
      for (int k = 0; k < 6; k++) begin
         chk("fair_gnt", at(acc_log, k), exp_f[k]);
         chk("fair_rsp", at(rsp_log, k), exp_f[k]);
      end

      // Backpressure: two accepts then full stall
      do_reset();
      post(0, 8'd255, 8'd255);
      post(1, 8'd17, 8'd3);
      post(2, 8'd100, 8'd200);
      repeat (5) step(1'b0);
      chk("bp_accepts", acc_log.size(), 2);
      chk("bp_ready", req_ready, 0);
      chk("bp_mul_a", mul_a, 17);
      chk("bp_mul_b", mul_b, 3);
      iter = 0;
      while (rsp_log.size() < 3 && iter < 20) begin
         step(1'b1);
         iter++;
      end
      chk("bp_drain", rsp_log.size(), 3);
      chk("bp_id0", at(rsp_log, 0), 0);
      chk("bp_id1", at(rsp_log, 1), 1);
      chk("bp_id2", at(rsp_log, 2), 2);
      chk("bp_d0", at(dat_log, 0), 65025);
      chk("bp_d1", at(dat_log, 1), 51);
      chk("bp_d2", at(dat_log, 2), 20000);

      // Async reset with two ops in flight
      do_reset();
      for (int c = 0; c < 4; c++) begin
         for (int i = 0; i < NR; i++) post(i, 8'(i + 9), 8'(c + 1));
         step(1'b1);
      end
      step(1'b0);
      chk("ar_pre_rsp", rsp_valid, 1);
      chk("ar_pre_s1", dut4.s1_valid, 1);
      chk("ar_pre_cnt", op_count, 2);
      #2 rst = 1'b1;
      #1;
      chk("ar_rsp_valid", rsp_valid, 0);
      chk("ar_s1_valid", dut4.s1_valid, 0);
      chk("ar_op_count", op_count, 0);
      chk("ar_ready", req_ready, 0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      post(3, 8'd4, 8'd4);
      post(1, 8'd5, 8'd5);
      step(1'b1);
      chk("ar_first_gnt", at(acc_log, 0), 1);
      repeat (4) step(1'b1);

      // Random traffic
      do_reset();
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < NR; i++)
            if ($urandom_range(1, 0) == 1)
               post(i, 8'($urandom), 8'($urandom));
         step(1'($urandom_range(3, 0) != 0));
      end
      iter = 0;
      while ((q.size() > 0 || pv[0] || pv[1] || pv[2] || pv[3])
             && iter < 40) begin
         step(1'b1);
         iter++;
      end
      chk("rand_drain", q.size(), 0);

      // Counter wrap after 65536 completions
      do_reset();
      iter = 0;
      while (cnt < 65536 && iter < 70000) begin
         for (int i = 0; i < NR; i++)
            post(i, 8'($urandom), 8'($urandom));
         step(1'b1);
         iter++;
      end
      chk("wrap_reached", cnt, 65536);
      @(negedge clk);
      chk("wrap_count", op_count, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/mul8u_share_sched.md
# mul8u_share_sched

Round-robin scheduler that shares one external 8x8 unsigned multiplier (exact or approximate library instance) among `N` requesters. Operands are accepted over per-requester valid/ready handshakes, registered into an issue stage that drives the multiplier, and the product is captured into a result stage. The result leaves on a single shared response channel tagged with the requester index. The block sits between accelerator lanes and a single FPGA-mapped multiplier, so one LUT-cheap approximate core serves several consumers.

## Interface
Parameters:
- `N`, 4: number of requesters, 2..16.
- `IDW`, `$clog2(N)`: requester-index width.

Ports (clock and reset first):
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `req_valid` in N: operand request, one bit per requester.
- `req_ready` out N: per-requester accept. Combinational from `req_valid` and pipeline state.
- `req_a` in N*8: operand A. Requester i uses bits [8i+7:8i].
- `req_b` in N*8: operand B, same packing as `req_a`.
- `mul_a` out 8: A operand to the external multiplier, driven from a register.
- `mul_b` out 8: B operand to the external multiplier, driven from a register.
- `mul_o` in 16: product from the external multiplier. Purely combinational in `mul_a`/`mul_b`.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: response consumer accept.
- `rsp_id` out IDW: index of the requester that issued the result.
- `rsp_data` out 16: registered `mul_o`.
- `op_count` out 16: completed responses (`rsp_valid & rsp_ready`). Wraps 0xFFFF -> 0.

## Operation
- Two pipeline stages:
  - S1 (issue): `s1_valid`, `s1_id`, and the `mul_a`/`mul_b` registers.
  - S2 (result): `rsp_valid`, `rsp_id`, `rsp_data`.
- S2 is free when `!rsp_valid | rsp_ready`.
- `s2_load = s1_valid & S2 free`.
- `s1_load_en = !s1_valid | s2_load`.
- Arbitration:
  - Round-robin pointer `rr_ptr` (IDW bits).
  - Grant goes to the first requester with `req_valid` set, searching from `rr_ptr` upward modulo N.
  - At most one `req_ready` bit is high, and only the granted bit when `s1_load_en` is high.
- Accept on `req_valid[g] & req_ready[g]`:
  - S1 loads `mul_a = req_a[g]`, `mul_b = req_b[g]`, `s1_id = g`, `s1_valid = 1`.
  - `rr_ptr` becomes `(g+1) mod N`. For non-power-of-2 N, wrap from N-1 to 0.
- On `s2_load`:
  - `rsp_data <= mul_o`, `rsp_id <= s1_id`, `rsp_valid <= 1`.
  - If there is no simultaneous accept, `s1_valid <= 0`. The `mul_a`/`mul_b` registers keep their value.
- Response completes on `rsp_valid & rsp_ready`. `rsp_valid` clears unless `s2_load` happens in the same cycle; in that case the new result replaces the old one with no bubble.
- While S1 is stalled, `mul_a`/`mul_b` do not change, so `mul_o` stays stable.
- When no request is valid, `rr_ptr` holds.
- Operand values are never altered. `rsp_data` is whatever the attached multiplier produces.

## Timing
- Reset (async assert) values:
  - `s1_valid` = 0, `rsp_valid` = 0.
  - `mul_a` = 0, `mul_b` = 0.
  - `rsp_data` = 0, `rsp_id` = 0.
  - `rr_ptr` = 0, `op_count` = 0.
  - `req_ready` = 0 while `rst` is high.
- Latency: accept at edge t -> `mul_a`/`mul_b` valid after t -> `rsp_valid` high after edge t+1, i.e. 2 cycles.
- Throughput: 1 op/cycle with `rsp_ready` held high.
- Full stall (`rsp_ready` = 0):
  - The first accept completes; S1 then holds one op and S2 holds one op.
  - After that, all `req_ready` = 0. Maximum in flight is 2.
- Simultaneous events:
  - Accept, S1->S2 move, and response pop can all occur in one cycle.
- Reset mid-operation: all in-flight ops are discarded. No response is produced for them.
- Requirement on requesters: `req_valid` must stay high with stable operands until accepted.

## Structure
- Package `mul8u_sched_pkg`:
  - `MUL_W = 8`, `PROD_W = 16`.
  - Typedef `mul_op_t {a[7:0], b[7:0]}`.
  - Typedef `mul_rsp_t {data[15:0]}`.
- Sub-module `rr_arbiter #(N)`:
  - Inputs: `req`, `ptr`.
  - Outputs: one-hot `gnt` and binary `gnt_id`.
  - Purely combinational.
  - The parent owns `rr_ptr`.
- The multiplier is not instantiated inside this block. The parent connects any 8x8 multiplier to `mul_a`/`mul_b`/`mul_o`.

## Test plan
Bench uses an exact behavioural multiplier on `mul_*`.
- Single op: N=4, requester 2 sends 200×150, `rsp_ready` held high -> `rsp_valid` 2 cycles after accept, `rsp_id` = 2, `rsp_data` = 30000, `op_count` = 1.
- Fairness: all 4 requesters valid continuously, distinct operands -> grant order 0,1,2,3,0,1, one response per cycle, `rsp_id` in that order.
- Backpressure: `rsp_ready` = 0 for 5 cycles with 3 requesters valid -> exactly 2 accepts, `req_ready` all 0 afterwards, `mul_a`/`mul_b` stable. After release, responses drain in accept order with correct products (e.g. 255×255 = 65025).
- Non-power-of-2: N=3, all valid -> pointer wraps 2 -> 0, grants 0,1,2,0.
- Async reset mid-stream: assert `rst` between clock edges with 2 ops in flight -> `rsp_valid`, `s1_valid`, and `op_count` go to 0 immediately. After release, first grant goes to the lowest valid index.
- Counter wrap: preload by running 65536 completions -> `op_count` reads 0.
